// File: rtl/alu_pkg.sv
// Op-select encodings and the decoded op type shared by the ALU core and pipeline.
package alu_pkg;

    localparam logic [3:0] FUNC_ADD  = 4'b0000;
    localparam logic [3:0] FUNC_SUB  = 4'b0001;
    localparam logic [3:0] FUNC_ADC  = 4'b0010;
    localparam logic [3:0] FUNC_SL   = 4'b0011;
    localparam logic [3:0] FUNC_SR   = 4'b0100;
    localparam logic [3:0] FUNC_STT  = 4'b0101;
    localparam logic [3:0] FUNC_STF  = 4'b0110;
    localparam logic [3:0] FUNC_SPEC = 4'b0111;
    localparam logic [3:0] FUNC_SLW  = 4'b1010;
    localparam logic [3:0] FUNC_SHG  = 4'b1011;
    localparam logic [3:0] FUNC_BE   = 4'b1100;
    localparam logic [3:0] FUNC_BLT  = 4'b1101;

    localparam logic [2:0] SPEC_INC  = 3'b000;
    localparam logic [2:0] SPEC_AND1 = 3'b001;
    localparam logic [2:0] SPEC_SUB8 = 3'b011;
    localparam logic [2:0] SPEC_PKR  = 3'b100;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_ADC, OP_SL, OP_SR, OP_STT, OP_STF,
        OP_INC, OP_AND1, OP_SUB8, OP_PKR, OP_SLW, OP_SHG,
        OP_BE, OP_BLT, OP_ILL
    } alu_op_e;

    // Flattens the two-level func/spec_fun encoding; anything unlisted is OP_ILL.
    function automatic alu_op_e decode_op(input logic [3:0] func, input logic [2:0] spec_fun);
        alu_op_e op;
        op = OP_ILL;
        case (func)
            FUNC_ADD: op = OP_ADD;
            FUNC_SUB: op = OP_SUB;
            FUNC_ADC: op = OP_ADC;
            FUNC_SL:  op = OP_SL;
            FUNC_SR:  op = OP_SR;
            FUNC_STT: op = OP_STT;
            FUNC_STF: op = OP_STF;
            FUNC_SPEC: begin
                case (spec_fun)
                    SPEC_INC:  op = OP_INC;
                    SPEC_AND1: op = OP_AND1;
                    SPEC_SUB8: op = OP_SUB8;
                    SPEC_PKR:  op = OP_PKR;
                    default:   op = OP_ILL;
                endcase
            end
            FUNC_SLW: op = OP_SLW;
            FUNC_SHG: op = OP_SHG;
            FUNC_BE:  op = OP_BE;
            FUNC_BLT: op = OP_BLT;
            default:  op = OP_ILL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: one op in, result/carry/branch/illegal out, plus
// qualifiers telling the pipeline whether the op touches carry flag or branch counters.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       func_i,
    input  logic [2:0]       spec_fun_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             br_o,
    output logic             illegal_o,
    output logic             carry_op_o,
    output logic             branch_op_o
);

    localparam int HALF = WIDTH / 2;

    alu_op_e          op;
    logic [WIDTH-1:0] pkr;

    // Each PKR bit is set when the 4-bit window starting at that bit is all ones.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pkr
            if (gi <= WIDTH - 4) begin : g_win
                assign pkr[gi] = &a_i[gi+3:gi];
            end else begin : g_zero
                assign pkr[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        op          = decode_op(func_i, spec_fun_i);
        res_o       = '0;
        carry_o     = 1'b0;
        br_o        = 1'b0;
        illegal_o   = 1'b0;
        carry_op_o  = 1'b0;
        branch_op_o = 1'b0;
        case (op)
            OP_ADD: begin
                {carry_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
                carry_op_o       = 1'b1;
            end
            OP_SUB: begin
                res_o      = a_i - b_i;
                carry_o    = (a_i < b_i);
                carry_op_o = 1'b1;
            end
            OP_ADC: begin
                {carry_o, res_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, carry_i};
                carry_op_o       = 1'b1;
            end
            OP_SL:   res_o = a_i << b_i;
            OP_SR:   res_o = a_i >> b_i;
            OP_STT:  res_o = b_i;
            OP_STF:  res_o = a_i;
            OP_INC:  res_o = a_i + WIDTH'(1);
            OP_AND1: res_o = a_i & WIDTH'(1);
            OP_SUB8: res_o = WIDTH'(8) - a_i;
            OP_PKR:  res_o = pkr;
            OP_SLW:  res_o = {a_i[WIDTH-1:HALF], b_i[HALF-1:0]};
            OP_SHG:  res_o = {b_i[HALF-1:0], a_i[HALF-1:0]};
            OP_BE: begin
                br_o        = (a_i == b_i);
                branch_op_o = 1'b1;
            end
            OP_BLT: begin
                br_o        = (a_i < b_i);
                branch_op_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready handshake, persistent carry flag and
// saturating branch taken/not-taken statistics.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [3:0]       func,
    input  logic [2:0]       spec_fun,
    input  logic             stat_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry_out,
    output logic             br_out,
    output logic             illegal_op,
    output logic [CNT_W-1:0] num_bran_taken,
    output logic [CNT_W-1:0] num_bran_not_taken
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             br_q, br_d;
    logic             illegal_q, illegal_d;
    logic             carry_flag_q, carry_flag_d;
    logic [CNT_W-1:0] taken_q, taken_d;
    logic [CNT_W-1:0] not_taken_q, not_taken_d;

    logic [WIDTH-1:0] core_res;
    logic             core_carry, core_br, core_ill, core_carry_op, core_branch_op;
    logic             accept;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i         (reg1),
        .b_i         (reg2),
        .func_i      (func),
        .spec_fun_i  (spec_fun),
        .carry_i     (carry_flag_q),
        .res_o       (core_res),
        .carry_o     (core_carry),
        .br_o        (core_br),
        .illegal_o   (core_ill),
        .carry_op_o  (core_carry_op),
        .branch_op_o (core_branch_op)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        res_d        = res_q;
        carry_d      = carry_q;
        br_d         = br_q;
        illegal_d    = illegal_q;
        carry_flag_d = carry_flag_q;
        taken_d      = taken_q;
        not_taken_d  = not_taken_q;

        if (accept) begin
            out_valid_d = 1'b1;
            res_d       = core_res;
            carry_d     = core_carry;
            br_d        = core_br;
            illegal_d   = core_ill;
            if (core_carry_op) begin
                carry_flag_d = core_carry;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear wins over a same-cycle branch so software sees a clean zero.
        if (stat_clr) begin
            taken_d     = '0;
            not_taken_d = '0;
        end else if (accept && core_branch_op) begin
            if (core_br) begin
                if (taken_q != CNT_MAX) taken_d = taken_q + CNT_W'(1);
            end else begin
                if (not_taken_q != CNT_MAX) not_taken_d = not_taken_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            br_q         <= 1'b0;
            illegal_q    <= 1'b0;
            carry_flag_q <= 1'b0;
            taken_q      <= '0;
            not_taken_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            br_q         <= br_d;
            illegal_q    <= illegal_d;
            carry_flag_q <= carry_flag_d;
            taken_q      <= taken_d;
            not_taken_q  <= not_taken_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign res                = res_q;
    assign carry_out          = carry_q;
    assign br_out             = br_q;
    assign illegal_op         = illegal_q;
    assign num_bran_taken     = taken_q;
    assign num_bran_not_taken = not_taken_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a driver pushes model results on each accepted op,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_alu_pipe;

    localparam int W     = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         br;
        logic         ill;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     reg1 = '0, reg2 = '0;
    logic [3:0]       func = '0;
    logic [2:0]       spec_fun = '0;
    logic             stat_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     res;
    logic             carry_out, br_out, illegal_op;
    logic [CNT_W-1:0] num_bran_taken, num_bran_not_taken;

    alu_pipe #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .reg1               (reg1),
        .reg2               (reg2),
        .func               (func),
        .spec_fun           (spec_fun),
        .stat_clr           (stat_clr),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .res                (res),
        .carry_out          (carry_out),
        .br_out             (br_out),
        .illegal_op         (illegal_op),
        .num_bran_taken     (num_bran_taken),
        .num_bran_not_taken (num_bran_not_taken)
    );

    initial forever #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   acc_now = 1'b0;
    bit   accepted = 1'b0;
    bit   rst_active = 1'b1;
    int   m_cf = 0, m_taken = 0, m_not = 0;
    int   n_cf = 0, n_taken = 0, n_not = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written directly from the op table with integer arithmetic.
    function automatic exp_t model(input int f, input int sf, input int a, input int b, input int cf);
        exp_t e;
        int   r;
        r = 0;
        e.c = 1'b0; e.br = 1'b0; e.ill = 1'b0;
        case (f)
            0:  begin r = a + b; e.c = (r >= 256); end
            1:  begin r = a - b; e.c = (a < b); end
            2:  begin r = a + b + cf; e.c = (r >= 256); end
            3:  r = (b >= W) ? 0 : (a << b);
            4:  r = (b >= W) ? 0 : (a >> b);
            5:  r = b;
            6:  r = a;
            7: begin
                case (sf)
                    0: r = a + 1;
                    1: r = a % 2;
                    3: r = 8 - a;
                    4: for (int i = 0; i <= W - 4; i++)
                           if (((a >> i) & 15) == 15) r += (1 << i);
                    default: e.ill = 1'b1;
                endcase
            end
            10: r = (a / 16) * 16 + (b % 16);
            11: r = (b % 16) * 16 + (a % 16);
            12: e.br = (a == b);
            13: e.br = (a < b);
            default: e.ill = 1'b1;
        endcase
        e.res = 8'(r & 255);
        return e;
    endfunction

    task automatic commit();
        m_cf = n_cf; m_taken = n_taken; m_not = n_not;
    endtask

    task automatic cycle(input bit v, input bit ordy, input logic [3:0] f, input logic [2:0] sf,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit clr);
        exp_t e;
        @(posedge clock); #2;
        commit();
        in_valid = v; out_ready = ordy; func = f; spec_fun = sf;
        reg1 = a; reg2 = b; stat_clr = clr;
        #1;
        acc_now  = v && (exp_q.size() == 0 || ordy);
        accepted = acc_now;
        if (acc_now) begin
            e = model(int'(f), int'(sf), int'(a), int'(b), m_cf);
            exp_q.push_back(e);
            if (!e.ill && f <= 4'd2) n_cf = int'(e.c);
            if (!clr && (f == 4'd12 || f == 4'd13)) begin
                if (e.br) n_taken = (n_taken < CMAX) ? n_taken + 1 : n_taken;
                else      n_not   = (n_not   < CMAX) ? n_not + 1   : n_not;
            end
        end
        if (clr) begin
            n_taken = 0; n_not = 0;
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [2:0] sf, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int n = 0;
        do begin
            cycle(1'b1, 1'b1, f, sf, a, b, 1'b0);
            n++;
        end while (!accepted && n < 20);
        if (!accepted) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b1, 4'd0, 3'd0, '0, '0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clock); #2;
        commit();
        acc_now = 1'b0; rst_active = 1'b1;
        reset = 1'b1; in_valid = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (n - 1) @(posedge clock);
        #2;
        reset = 1'b0;
        exp_q.delete();
        m_cf = 0; m_taken = 0; m_not = 0;
        n_cf = 0; n_taken = 0; n_not = 0;
        rst_active = 1'b0;
    endtask

    // Monitor: compares presented results against the queue head and pops on transfer.
    initial begin
        exp_t e;
        bit   ev;
        forever begin
            @(negedge clock);
            if (!rst_active) begin
                ev = (exp_q.size() - (acc_now ? 1 : 0)) > 0;
                chk("out_valid", 32'(out_valid), 32'(ev));
                chk("in_ready", 32'(in_ready), 32'(!ev || out_ready));
                chk("taken", 32'(num_bran_taken), 32'(m_taken));
                chk("not_taken", 32'(num_bran_not_taken), 32'(m_not));
                if (ev) begin
                    e = exp_q[0];
                    chk("res", 32'(res), 32'(e.res));
                    chk("carry_out", 32'(carry_out), 32'(e.c));
                    chk("br_out", 32'(br_out), 32'(e.br));
                    chk("illegal_op", 32'(illegal_op), 32'(e.ill));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   f;
        logic [2:0]   sf;
        logic [W-1:0] a, b;

        do_reset(2);
        @(negedge clock);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_br", 32'(br_out), 32'd0);
        chk("rst_ill", 32'(illegal_op), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        issue(4'd0, 3'd0, 8'hF0, 8'h20);
        issue(4'd2, 3'd0, 8'h01, 8'h01);

        issue(4'd12, 3'd0, 8'd5, 8'd5);
        issue(4'd12, 3'd0, 8'd5, 8'd6);
        issue(4'd13, 3'd0, 8'd3, 8'd9);
        idle(2);
        @(negedge clock);
        chk("dir_taken", 32'(num_bran_taken), 32'd2);
        chk("dir_not_taken", 32'(num_bran_not_taken), 32'd1);
        cycle(1'b1, 1'b1, 4'd13, 3'd0, 8'd3, 8'd9, 1'b1);
        idle(2);
        @(negedge clock);
        chk("clr_taken", 32'(num_bran_taken), 32'd0);
        chk("clr_not_taken", 32'(num_bran_not_taken), 32'd0);

        cycle(1'b1, 1'b0, 4'd1, 3'd0, 8'h02, 8'h03, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 4'd0, 3'd0, 8'h11, 8'h22, 1'b0);
        cycle(1'b1, 1'b1, 4'd0, 3'd0, 8'h11, 8'h22, 1'b0);
        chk("drain_accept", 32'(accepted), 32'd1);
        idle(2);

        issue(4'd7, 3'd4, 8'b0111_1100, 8'h00);
        issue(4'd4, 3'd0, 8'h80, 8'd8);
        issue(4'd14, 3'd0, 8'h55, 8'hAA);
        idle(2);

        repeat (4) issue(4'd12, 3'd0, 8'd7, 8'd7);
        idle(2);
        @(negedge clock);
        chk("sat_taken", 32'(num_bran_taken), 32'(CMAX));

        cycle(1'b1, 1'b0, 4'd0, 3'd0, 8'h01, 8'h02, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 1'b0);
        do_reset(2);

        for (int i = 0; i < 600; i++) begin
            f  = 4'($urandom_range(0, 15));
            sf = 3'($urandom_range(0, 7));
            case ($urandom % 4)
                0:       a = 8'h00;
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            b = 8'($urandom);
            if (f == 4'd3 || f == 4'd4) b = 8'($urandom_range(0, 10));
            if ($urandom % 3 == 0) b = a;
            if (i == 300) do_reset(2);
            cycle(($urandom % 4) != 0, ($urandom % 4) != 0, f, sf, a, b, ($urandom % 16) == 0);
        end
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
